fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_sweep_counter.sv | 40 ++++
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default geometry, pixel width, coordinate width
// and the write-arbiter state encoding.
package fb_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int DW    = 8;
  localparam int CW    = 10;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // True when (x, y) addresses a pixel inside an h-by-v frame.
  function automatic logic in_frame(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                    input int h, input int v);
    return (int'(x) < h) && (int'(y) < v);
  endfunction

endpackage

// File: rtl/fb_sweep_counter.sv
// Raster-order pixel counter for the clear sweep: x advances fastest, y on x wrap,
// with a flag marking the final pixel of the frame.
module fb_sweep_counter import fb_pkg::*; #(
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] X_MAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_RES - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (restart) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates two pixel-write channels onto the framebuffer's single write port,
// with a full-frame clear sweep that pre-empts both channels.
module fb_write_arbiter import fb_pkg::*; #(
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES,
  parameter int DW    = fb_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ch1_req,
  input  logic [CW-1:0] ch1_x,
  input  logic [CW-1:0] ch1_y,
  input  logic [DW-1:0] ch1_data,
  input  logic          ch2_req,
  input  logic [CW-1:0] ch2_x,
  input  logic [CW-1:0] ch2_y,
  input  logic [DW-1:0] ch2_data,
  output logic          ch1_grant,
  output logic          ch2_grant,
  input  logic          clear_start,
  input  logic [DW-1:0] clear_color,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          drop,
  output logic          mem_we,
  output logic [CW-1:0] mem_x,
  output logic [CW-1:0] mem_y,
  output logic [DW-1:0] mem_data
);

  fb_state_e     state_q, state_d;
  logic          prefer_ch2_q;
  logic          sweep_end_q;
  logic          start_clear;
  logic          sweep_en;
  logic          sweep_last;
  logic [CW-1:0] sweep_x, sweep_y;
  logic [CW-1:0] sel_x, sel_y;
  logic [DW-1:0] sel_data;
  logic [DW-1:0] color_q;

  fb_sweep_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .restart (start_clear),
    .en      (sweep_en),
    .x       (sweep_x),
    .y       (sweep_y),
    .last    (sweep_last)
  );

  // sweep_end_q marks the drain cycle: the last clear write is on the bus and
  // the counter must not advance again.
  assign sweep_en   = (state_q == ST_CLEAR) && !sweep_end_q;
  assign clear_busy = (state_q == ST_CLEAR);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ch1_grant   = 1'b0;
    ch2_grant   = 1'b0;
    start_clear = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          start_clear = 1'b1;
          state_d     = ST_CLEAR;
        end else if (ch1_req && (!ch2_req || !prefer_ch2_q)) begin
          ch1_grant = 1'b1;
        end else if (ch2_req) begin
          ch2_grant = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (sweep_end_q) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign sel_x    = ch2_grant ? ch2_x    : ch1_x;
  assign sel_y    = ch2_grant ? ch2_y    : ch1_y;
  assign sel_data = ch2_grant ? ch2_data : ch1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARB;
      prefer_ch2_q <= 1'b0;
      sweep_end_q  <= 1'b0;
      color_q      <= '0;
      mem_we       <= 1'b0;
      mem_x        <= '0;
      mem_y        <= '0;
      mem_data     <= '0;
      drop         <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_we     <= 1'b0;
      drop       <= 1'b0;
      clear_done <= (state_q == ST_CLEAR) && sweep_end_q;

      if (start_clear) color_q <= clear_color;

      if (sweep_en) begin
        sweep_end_q <= sweep_last;
        mem_we      <= 1'b1;
        mem_x       <= sweep_x;
        mem_y       <= sweep_y;
        mem_data    <= color_q;
      end else if (sweep_end_q) begin
        sweep_end_q <= 1'b0;
      end

      // Out-of-frame requests are still consumed; they only suppress the write.
      if (ch1_grant || ch2_grant) begin
        prefer_ch2_q <= ch1_grant;
        if (in_frame(sel_x, sel_y, H_RES, V_RES)) begin
          mem_we   <= 1'b1;
          mem_x    <= sel_x;
          mem_y    <= sel_y;
          mem_data <= sel_data;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter on a reduced 16x8 frame: a cycle-level reference model
// checks every output each cycle, plus directed scenarios with literal expectations.
module tb_fb_write_arbiter;

  localparam int H = 16;
  localparam int V = 8;
  localparam int P = H * V;

  logic       clk = 1'b0;
  logic       reset;
  logic       ch1_req, ch2_req;
  logic [9:0] ch1_x, ch1_y, ch2_x, ch2_y;
  logic [7:0] ch1_data, ch2_data;
  logic       ch1_grant, ch2_grant;
  logic       clear_start;
  logic [7:0] clear_color;
  logic       clear_busy, clear_done, drop;
  logic       mem_we;
  logic [9:0] mem_x, mem_y;
  logic [7:0] mem_data;

  always #5 clk = ~clk;

  fb_write_arbiter #(.H_RES(H), .V_RES(V), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .ch1_req(ch1_req), .ch1_x(ch1_x), .ch1_y(ch1_y), .ch1_data(ch1_data),
    .ch2_req(ch2_req), .ch2_x(ch2_x), .ch2_y(ch2_y), .ch2_data(ch2_data),
    .ch1_grant(ch1_grant), .ch2_grant(ch2_grant),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .drop(drop),
    .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
  } wr_t;
  wr_t log_q[$];

  // Reference model: last granted channel, clear progress in cycles since start,
  // and the registered outputs expected in the following cycle.
  int         m_last;
  int         m_clr_c;
  logic [7:0] m_color;
  logic       n_we, n_drop, n_done;
  logic [9:0] n_x, n_y;
  logic [7:0] n_d;

  always @(negedge clk) begin
    int win;
    if (reset) begin
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_x", mem_x, 0);
      check("rst_mem_y", mem_y, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_busy", clear_busy, 0);
      check("rst_done", clear_done, 0);
      check("rst_drop", drop, 0);
      m_last = 2; m_clr_c = 0; m_color = '0;
      n_we = 0; n_drop = 0; n_done = 0; n_x = '0; n_y = '0; n_d = '0;
    end else begin
      check("mem_we", mem_we, n_we);
      if (n_we) begin
        check("mem_x", mem_x, n_x);
        check("mem_y", mem_y, n_y);
        check("mem_data", mem_data, n_d);
      end
      if (mem_we) log_q.push_back('{x: mem_x, y: mem_y, d: mem_data});
      check("drop", drop, n_drop);
      check("clear_done", clear_done, n_done);
      check("clear_busy", clear_busy, m_clr_c > 0);

      win = 0;
      if (m_clr_c == 0 && !clear_start) begin
        if (ch1_req && ch2_req) win = (m_last == 1) ? 2 : 1;
        else if (ch1_req)       win = 1;
        else if (ch2_req)       win = 2;
      end
      check("ch1_grant", ch1_grant, win == 1);
      check("ch2_grant", ch2_grant, win == 2);

      n_we = 0; n_drop = 0; n_done = 0;
      if (m_clr_c > 0) begin
        if (m_clr_c <= P) begin
          n_we = 1;
          n_x  = 10'((m_clr_c - 1) % H);
          n_y  = 10'((m_clr_c - 1) / H);
          n_d  = m_color;
        end
        m_clr_c++;
        if (m_clr_c == P + 2) begin
          n_done  = 1;
          m_clr_c = 0;
        end
      end else if (clear_start) begin
        m_clr_c = 1;
        m_color = clear_color;
      end else if (win != 0) begin
        m_last = win;
        if (win == 1) begin n_x = ch1_x; n_y = ch1_y; n_d = ch1_data; end
        else          begin n_x = ch2_x; n_y = ch2_y; n_d = ch2_data; end
        if (int'(n_x) < H && int'(n_y) < V) n_we = 1;
        else                                n_drop = 1;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for clear_done within a bounded budget; counts ch1 grants seen before it.
  task automatic wait_done(input string name, output int early);
    bit seen;
    seen  = 0;
    early = 0;
    for (int i = 0; i < P + 20 && !seen; i++) begin
      @(negedge clk);
      if (clear_done) seen = 1;
      else if (ch1_grant) early++;
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g[6];
    int  early, base, n, bad_data;

    reset = 1'b1; ch1_req = 0; ch2_req = 0; clear_start = 0; clear_color = '0;
    ch1_x = '0; ch1_y = '0; ch1_data = '0; ch2_x = '0; ch2_y = '0; ch2_data = '0;
    step(3);
    reset = 1'b0;
    step(2);

    // Single ch1 request.
    ch1_req = 1; ch1_x = 10'd5; ch1_y = 10'd7; ch1_data = 8'h3C;
    @(negedge clk);
    check("t1_grant", ch1_grant, 1);
    step(); ch1_req = 0;
    @(negedge clk);
    check("t1_we", mem_we, 1);
    check("t1_x", mem_x, 5);
    check("t1_y", mem_y, 7);
    check("t1_data", mem_data, 8'h3C);
    step(2);

    // Both channels from reset: strict alternation starting with ch1.
    reset = 1; step(2); reset = 0;
    ch1_req = 1; ch1_x = 10'd1; ch1_y = 10'd2; ch1_data = 8'h11;
    ch2_req = 1; ch2_x = 10'd3; ch2_y = 10'd4; ch2_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g[i] = ch2_grant ? 2 : (ch1_grant ? 1 : 0);
      check("t2_order", g[i], (i % 2 == 0) ? 1 : 2);
      if (i > 0) begin
        check("t2_we", mem_we, 1);
        check("t2_data", mem_data, (i % 2 == 1) ? 8'h11 : 8'h22);
      end
      step();
    end
    ch1_req = 0; ch2_req = 0;
    step(2);

    // Out-of-frame ch2 requests are consumed and dropped.
    ch2_req = 1; ch2_x = 10'(H); ch2_y = 10'd0;
    @(negedge clk);
    check("t3_grant_a", ch2_grant, 1);
    step(); ch2_x = 10'd0; ch2_y = 10'(V);
    @(negedge clk);
    check("t3_grant_b", ch2_grant, 1);
    check("t3_we_a", mem_we, 0);
    check("t3_drop_a", drop, 1);
    step(); ch2_req = 0;
    @(negedge clk);
    check("t3_we_b", mem_we, 0);
    check("t3_drop_b", drop, 1);
    step(2);

    // Clear to 0x00 with ch1 held during the sweep.
    clear_start = 1; clear_color = 8'h00;
    step(); clear_start = 0;
    base = log_q.size();
    ch1_req = 1; ch1_x = 10'd5; ch1_y = 10'd5; ch1_data = 8'h99;
    wait_done("t4", early);
    check("t4_no_early_grant", early, 0);
    check("t4_grant_at_done", ch1_grant, 1);
    n = log_q.size() - base;
    check("t4_count", n, P);
    if (n >= P) begin
      check("t4_first_x", log_q[base].x, 0);
      check("t4_first_y", log_q[base].y, 0);
      check("t4_rowend_x", log_q[base + H - 1].x, H - 1);
      check("t4_rowend_y", log_q[base + H - 1].y, 0);
      check("t4_row1_x", log_q[base + H].x, 0);
      check("t4_row1_y", log_q[base + H].y, 1);
      check("t4_last_x", log_q[base + P - 1].x, H - 1);
      check("t4_last_y", log_q[base + P - 1].y, V - 1);
    end
    step(); ch1_req = 0;
    step(2);

    // Clear and request together; a second clear_start mid-sweep is ignored.
    clear_start = 1; clear_color = 8'h77;
    ch1_req = 1; ch1_x = 10'd2; ch1_y = 10'd2; ch1_data = 8'h44;
    @(negedge clk);
    check("t5_no_grant", ch1_grant, 0);
    step(); clear_start = 0;
    base = log_q.size();
    step(20);
    clear_start = 1; clear_color = 8'h11;
    step(); clear_start = 0;
    wait_done("t5", early);
    n = log_q.size() - base;
    check("t5_count", n, P);
    bad_data = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].d !== 8'h77) bad_data++;
    check("t5_color", bad_data, 0);
    step(); ch1_req = 0;
    step(2);

    // Reset mid-sweep aborts it and nothing resumes.
    clear_start = 1; clear_color = 8'h5A;
    step(); clear_start = 0;
    n = 0;
    for (int i = 0; i < P && n < 50; i++) begin
      @(negedge clk);
      if (mem_we) n++;
    end
    check("t6_reached_50", n, 50);
    #1 reset = 1;
    #1;
    check("t6_we_now", mem_we, 0);
    check("t6_busy_now", clear_busy, 0);
    step(2);
    reset = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) n++;
    end
    check("t6_no_writes", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
